// File: rtl/coin_accum_fsm.sv
// coin_accum_fsm: coin credit accumulator with price latch, sale completion, cancel and timeout refund
module coin_accum_fsm #(
  parameter int NUM_COINS = 4,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALS = {8'd10, 8'd5, 8'd2, 8'd1},
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic [CREDIT_W-1:0]  price,
  input  logic                 cancel,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic                 state_cmp,
  output logic                 out_rdy,
  output logic [CREDIT_W-1:0]  data_out,
  output logic [CREDIT_W-1:0]  change_out,
  output logic                 refund_vld,
  output logic [CREDIT_W-1:0]  refund_amt,
  output logic                 coin_rej
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE, REFUND} state_t;
  state_t state;
  logic [CREDIT_W-1:0] price_q;
  logic [CREDIT_W-1:0] value;
  logic [CREDIT_W:0] sum;
  logic [CNT_W-1:0] cnt;
  logic one_hot;
  logic any_coin;
  always_comb begin
    value = '0;
    for (int i = 0; i < NUM_COINS; i++) value = value | (coin_in[i] ? COIN_VALS[i*CREDIT_W +: CREDIT_W] : '0);
    any_coin = |coin_in;
    one_hot = $onehot(coin_in);
    sum = {1'b0, credit} + {1'b0, value};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      credit <= '0;
      price_q <= '0;
      cnt <= '0;
      busy <= 1'b0;
      state_cmp <= 1'b0;
      out_rdy <= 1'b0;
      data_out <= '0;
      change_out <= '0;
      refund_vld <= 1'b0;
      refund_amt <= '0;
      coin_rej <= 1'b0;
    end else begin
      state_cmp <= 1'b0;
      out_rdy <= 1'b0;
      refund_vld <= 1'b0;
      coin_rej <= 1'b0;
      case (state)
        IDLE: begin
          coin_rej <= any_coin && !one_hot;
          if (one_hot) begin
            price_q <= price;
            credit <= value;
            cnt <= '0;
            busy <= 1'b1;
            if (value >= price) begin
              state <= DONE;
              out_rdy <= 1'b1;
              state_cmp <= 1'b1;
              data_out <= value;
              change_out <= value - price;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (cancel) begin
            state <= REFUND;
            refund_vld <= 1'b1;
            refund_amt <= credit;
            coin_rej <= any_coin;
          end else if (one_hot && !sum[CREDIT_W]) begin
            credit <= sum[CREDIT_W-1:0];
            cnt <= '0;
            if (sum >= {1'b0, price_q}) begin
              state <= DONE;
              out_rdy <= 1'b1;
              state_cmp <= 1'b1;
              data_out <= sum[CREDIT_W-1:0];
              change_out <= sum[CREDIT_W-1:0] - price_q;
            end
          end else begin
            coin_rej <= any_coin;
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
              state <= REFUND;
              refund_vld <= 1'b1;
              refund_amt <= credit;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          credit <= '0;
          cnt <= '0;
          coin_rej <= any_coin;
        end
      endcase
    end
  end
endmodule
